// File: rtl/mux_n_pipe_pkg.sv
// Shared types and helpers for the registered N-input selection stage.
// Optional skid buffer is controlled by macro MUX_N_PIPE_SKID_EN.
package mux_pkg;

  // Storage occupancy of the stage; TWO is only reachable with the skid buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } st_t;

  localparam int NIN_MAX = 16;

  // Select width for n inputs, never narrower than one bit.
  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_n_sel.sv
// Combinational word selector: picks Datos[sel] or, for an out-of-range select,
// falls back to the last legal word and raises the error bit.
module mux_n_sel
  import mux_pkg::*;
#(
  parameter  int DB  = 32,
  parameter  int NIN = 4,
  localparam int SW  = sel_w(NIN)
) (
  input  logic [NIN*DB-1:0] i_datos,
  input  logic [SW-1:0]     i_sel,
  input  logic [DB-1:0]     i_last,
  output logic [DB-1:0]     o_word,
  output logic              o_err
);

  // Scan the legal inputs so an out-of-range select never indexes past Datos.
  always_comb begin
    o_word = i_last;
    o_err  = 1'b1;
    for (int i = 0; i < NIN; i++) begin
      if (i_sel == SW'(i)) begin
        o_word = i_datos[i*DB +: DB];
        o_err  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_n_pipe.sv
// Registered N-input selection stage with valid/ready handshake and flush.
// Define MUX_N_PIPE_SKID_EN for a two-word skid buffer with registered in_ready;
// otherwise the stage holds one word and in_ready is combinational from out_ready.
module mux_n_pipe
  import mux_pkg::*;
#(
  parameter  int DB  = 32,
  parameter  int NIN = 4,
  localparam int SW  = sel_w(NIN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NIN*DB-1:0] Datos,
  input  logic [SW-1:0]     Sel,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              Flush,
  output logic [DB-1:0]     Salida,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              SelErr
);

  st_t           r_state;
  st_t           w_state_nxt;
  logic [DB-1:0] r_main;
  logic          r_main_err;
  logic [DB-1:0] r_last;
  logic          r_out_valid;
  logic [DB-1:0] w_word;
  logic          w_err;
  logic          w_accept;
  logic          w_consume;

  mux_n_sel #(.DB(DB), .NIN(NIN)) u_sel (
    .i_datos (Datos),
    .i_sel   (Sel),
    .i_last  (r_last),
    .o_word  (w_word),
    .o_err   (w_err)
  );

`ifdef MUX_N_PIPE_SKID_EN
  logic [DB-1:0] r_skid;
  logic          r_skid_err;
  logic          r_in_ready;

  assign in_ready = r_in_ready && !Flush;
`else
  assign in_ready = (!r_out_valid || out_ready) && !Flush;
`endif

  assign w_accept  = in_valid && in_ready;
  assign w_consume = r_out_valid && out_ready;
  assign Salida    = r_main;
  assign SelErr    = r_main_err;
  assign out_valid = r_out_valid;

  // Next occupancy; flush wins over any accept or consume in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    if (Flush) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY: if (w_accept) w_state_nxt = ONE;
        ONE: begin
`ifdef MUX_N_PIPE_SKID_EN
          if (w_accept && !w_consume) w_state_nxt = TWO;
          else if (!w_accept && w_consume) w_state_nxt = EMPTY;
`else
          if (!w_accept && w_consume) w_state_nxt = EMPTY;
`endif
        end
`ifdef MUX_N_PIPE_SKID_EN
        TWO: if (w_consume) w_state_nxt = ONE;
`endif
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  // Occupancy register; out_valid is kept as its own flop so it is a clean register output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= EMPTY;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= (w_state_nxt != EMPTY);
    end
  end

`ifdef MUX_N_PIPE_SKID_EN
  // Registered ready: drops the cycle after the skid slot fills, no path from out_ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_in_ready <= 1'b1;
    else       r_in_ready <= (w_state_nxt != TWO);
  end
`endif

  // Data registers: main, optional skid, and the last legal word for out-of-range fallback.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main     <= '0;
      r_main_err <= 1'b0;
      r_last     <= '0;
`ifdef MUX_N_PIPE_SKID_EN
      r_skid     <= '0;
      r_skid_err <= 1'b0;
`endif
    end else if (!Flush) begin
      if (w_accept && !w_err) r_last <= w_word;
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            r_main     <= w_word;
            r_main_err <= w_err;
          end
        end
        ONE: begin
          if (w_accept && w_consume) begin
            r_main     <= w_word;
            r_main_err <= w_err;
          end
`ifdef MUX_N_PIPE_SKID_EN
          else if (w_accept) begin
            r_skid     <= w_word;
            r_skid_err <= w_err;
          end
`endif
        end
`ifdef MUX_N_PIPE_SKID_EN
        TWO: begin
          if (w_consume) begin
            r_main     <= r_skid;
            r_main_err <= r_skid_err;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_n_pipe.sv
// Directed, table-driven bench for mux_n_pipe (NIN=4 instance plus NIN=3 for
// out-of-range selects). Expectations follow MUX_N_PIPE_SKID_EN when defined.
module tb_mux_n_pipe;

  logic         clk;
  logic         reset;

  logic [127:0] d4;
  logic [1:0]   s4;
  logic         iv4, ir4, fl4, ov4, or4, se4;
  logic [31:0]  q4;

  logic [95:0]  d3;
  logic [1:0]   s3;
  logic         iv3, ir3, fl3, ov3, or3, se3;
  logic [31:0]  q3;

  int n_cmp = 0;
  int n_bad = 0;

  mux_n_pipe #(.DB(32), .NIN(4)) u_dut4 (
    .clk(clk), .reset(reset), .Datos(d4), .Sel(s4), .in_valid(iv4),
    .in_ready(ir4), .Flush(fl4), .Salida(q4), .out_valid(ov4),
    .out_ready(or4), .SelErr(se4)
  );

  mux_n_pipe #(.DB(32), .NIN(3)) u_dut3 (
    .clk(clk), .reset(reset), .Datos(d3), .Sel(s3), .in_valid(iv3),
    .in_ready(ir3), .Flush(fl3), .Salida(q3), .out_valid(ov3),
    .out_ready(or3), .SelErr(se3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic        ordy;
    logic        fl;
    logic [1:0]  sel;
    logic [31:0] base;
    logic        exp_rdy;
    logic        exp_v;
    logic [31:0] exp_d;
    logic        exp_e;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_d4(input logic [31:0] base);
    for (int i = 0; i < 4; i++) d4[i*32 +: 32] = base + 32'(i);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 8; k++) begin
      vecs[k] = '{1'b1, 1'b1, 1'b0, 2'(k % 4), 32'h100 * 32'(k + 1),
                  1'b1, 1'b1, 32'h100 * 32'(k + 1) + 32'(k % 4), 1'b0};
    end
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 2'd0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 2'd1, 32'hA00, 1'b1, 1'b1, 32'hA01, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 2'd3, 32'hB00, 1'b0, 1'b0, 32'h0,   1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 2'd0, 32'hC00, 1'b1, 1'b1, 32'hC00, 1'b0};

    reset = 1'b1;
    d4 = '0; s4 = '0; iv4 = 1'b0; fl4 = 1'b0; or4 = 1'b0;
    d3 = '0; s3 = '0; iv3 = 1'b0; fl3 = 1'b0; or3 = 1'b0;
    #12 reset = 1'b0;
    tick;

    // reset state
    chk("rst_out_valid", 32'(ov4), 32'd0);
    chk("rst_salida", q4, 32'h0);
    chk("rst_selerr", 32'(se4), 32'd0);
    chk("rst_in_ready", 32'(ir4), 32'd1);
    chk("rst3_in_ready", 32'(ir3), 32'd1);

    // single accept, Sel=2
    set_d4(32'h0);
    d4[2*32 +: 32] = 32'hDEADBEEF;
    s4 = 2'd2; iv4 = 1'b1;
    tick;
    chk("single_valid", 32'(ov4), 32'd1);
    chk("single_salida", q4, 32'hDEADBEEF);
    chk("single_selerr", 32'(se4), 32'd0);

    // streaming, bubble, flush with accept, recovery
    for (int k = 0; k < 12; k++) begin
      iv4 = vecs[k].iv; or4 = vecs[k].ordy; fl4 = vecs[k].fl; s4 = vecs[k].sel;
      set_d4(vecs[k].base);
      #1;
      chk($sformatf("vec%0d_in_ready", k), 32'(ir4), 32'(vecs[k].exp_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_out_valid", k), 32'(ov4), 32'(vecs[k].exp_v));
      if (vecs[k].exp_v) begin
        chk($sformatf("vec%0d_salida", k), q4, vecs[k].exp_d);
        chk($sformatf("vec%0d_selerr", k), 32'(se4), 32'(vecs[k].exp_e));
      end
    end
    iv4 = 1'b0; fl4 = 1'b0; or4 = 1'b1;
    tick;
    chk("drain_valid", 32'(ov4), 32'd0);

    // out-of-range selects on the NIN=3 instance
    or3 = 1'b1; iv3 = 1'b1;
    d3 = {32'h33, 32'h22, 32'h11}; s3 = 2'd3;
    tick;
    chk("oor_first_salida", q3, 32'h0);
    chk("oor_first_err", 32'(se3), 32'd1);
    d3 = {32'h0, 32'h5, 32'h0}; s3 = 2'd1;
    tick;
    chk("oor_legal_salida", q3, 32'h5);
    chk("oor_legal_err", 32'(se3), 32'd0);
    d3 = {32'h77, 32'h77, 32'h77}; s3 = 2'd3;
    tick;
    chk("oor_hold_salida", q3, 32'h5);
    chk("oor_hold_err", 32'(se3), 32'd1);
    chk("oor_hold_valid", 32'(ov3), 32'd1);
    d3 = {32'h0, 32'h0, 32'h9}; s3 = 2'd0;
    tick;
    chk("oor_after_salida", q3, 32'h9);
    chk("oor_after_err", 32'(se3), 32'd0);
    iv3 = 1'b0;

    // backpressure: A then B with out_ready low
    or4 = 1'b0; iv4 = 1'b1; s4 = 2'd0; set_d4(32'hA0);
    #1;
    chk("bp_a_ready", 32'(ir4), 32'd1);
    @(posedge clk); #1;
    chk("bp_a_valid", 32'(ov4), 32'd1);
    chk("bp_a_salida", q4, 32'hA0);
    s4 = 2'd1; set_d4(32'hB0);
    #1;
`ifdef MUX_N_PIPE_SKID_EN
    chk("bp_b_ready", 32'(ir4), 32'd1);
    @(posedge clk); #1;
    chk("bp_full_ready", 32'(ir4), 32'd0);
    chk("bp_full_salida", q4, 32'hA0);
    iv4 = 1'b0; or4 = 1'b1;
    tick;
    chk("bp_b_valid", 32'(ov4), 32'd1);
    chk("bp_b_salida", q4, 32'hB1);
    chk("bp_ready_back", 32'(ir4), 32'd1);
    tick;
    chk("bp_empty_valid", 32'(ov4), 32'd0);
`else
    chk("bp_b_ready", 32'(ir4), 32'd0);
    @(posedge clk); #1;
    chk("bp_stall_salida", q4, 32'hA0);
    chk("bp_stall_valid", 32'(ov4), 32'd1);
    iv4 = 1'b0; or4 = 1'b1;
    #1;
    chk("bp_ready_back", 32'(ir4), 32'd1);
    @(posedge clk); #1;
    chk("bp_empty_valid", 32'(ov4), 32'd0);
    iv4 = 1'b1;
    tick;
    chk("bp_b_valid", 32'(ov4), 32'd1);
    chk("bp_b_salida", q4, 32'hB1);
    iv4 = 1'b0;
    tick;
    chk("bp_drained_valid", 32'(ov4), 32'd0);
`endif

    // asynchronous reset while words are held
    or4 = 1'b0; iv4 = 1'b1; s4 = 2'd2; set_d4(32'hE0);
    tick;
`ifdef MUX_N_PIPE_SKID_EN
    s4 = 2'd3;
    tick;
    chk("ar_pre_ready", 32'(ir4), 32'd0);
`endif
    iv4 = 1'b0;
    chk("ar_pre_valid", 32'(ov4), 32'd1);
    chk("ar_pre_salida", q4, 32'hE2);
    #2 reset = 1'b1;
    #1;
    chk("ar_valid", 32'(ov4), 32'd0);
    chk("ar_salida", q4, 32'h0);
    chk("ar_selerr", 32'(se4), 32'd0);
    #3 reset = 1'b0;
    tick;
    chk("ar_post_valid", 32'(ov4), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
